hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Control-side partner of the ID/EX pipeline register. It consumes the Execute-stage fields that the register produces (RdE, Rs1E, Rs2E, RegWriteE, ResultSrcE) together with the Decode-stage source registers and the taken-branch signal.
- It generates the stall, flush and clear controls for the IF/ID and ID/EX registers, and the operand-forwarding selects for the Execute stage.
- Internally it keeps a shadow pipeline of destination-register info for the MEM and WB stages, so it needs no EX/MEM or MEM/WB taps. It also holds saturating hazard-event counters.

Parameters:
- CNT_W, 32, width of the stall and flush event counters.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- Rs1D  in  5  Decode-stage rs1
- Rs2D  in  5  Decode-stage rs2
- Rs1E  in  5  Execute-stage rs1 (from ID/EX)
- Rs2E  in  5  Execute-stage rs2 (from ID/EX)
- RdE  in  5  Execute-stage rd (from ID/EX)
- RegWriteE  in  1  Execute-stage register write enable
- ResultSrcE  in  2  Execute-stage result select; 2'b01 = load
- PCSrcE  in  1  branch or jump taken in Execute
- cnt_clr  in  1  synchronous clear of both counters
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID
- FlushD  out  1  clear IF/ID
- FlushE  out  1  drives the clear input of ID/EX
- ForwardAE  out  2  ALU operand A select
- ForwardBE  out  2  ALU operand B select
- stall_cnt  out  CNT_W  number of load-use stall cycles
- flush_cnt  out  CNT_W  number of taken-branch flush cycles

Behaviour:
- Shadow pipeline:
  - Every clk edge: RdM<=RdE, RegWriteM<=RegWriteE, RdW<=RdM, RegWriteW<=RegWriteM.
  - A bubble inserted by FlushE arrives with RegWriteE=0, so the shadow needs no special handling.
  - On reset, all shadow registers go to 0.
- Load-use detection (combinational):
  - lwStall = (ResultSrcE==2'b01) & RegWriteE & (RdE!=0) & (Rs1D==RdE | Rs2D==RdE).
- Control outputs (combinational, same cycle, no added latency):
  - StallF = StallD = lwStall & ~PCSrcE. A taken branch wins; the instruction in Decode is wrong-path.
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE.
- Forwarding, ForwardAE (ForwardBE is identical using Rs2E):
  - 2'b10 if RegWriteM & RdM!=0 & Rs1E==RdM (MEM has priority).
  - else 2'b01 if RegWriteW & RdW!=0 & Rs1E==RdW.
  - else 2'b00.
  - x0 never forwards.
- Counters:
  - stall_cnt increments on every cycle where StallD=1.
  - flush_cnt increments on every cycle where PCSrcE=1.
  - Both saturate at all-ones and never wrap.
  - cnt_clr has priority over increment; the counter value becomes 0 on the next edge.
- Reset:
  - Counters and shadow registers are cleared to 0 asynchronously.
  - With inputs at 0, all control outputs evaluate to 0 while reset is held.
  - Reset asserted mid-stall: the shadow state is lost and forwarding is disabled until new writes propagate.
- Simultaneous events:
  - A load-use stall and PCSrcE in the same cycle gives FlushD=1, FlushE=1, StallF=StallD=0, stall_cnt unchanged, flush_cnt +1.

Decomposition:
- Shared package holds:
  - RESULT_ALU=2'b00, RESULT_MEM=2'b01, RESULT_PC4=2'b10.
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - REG_X0=5'd0.
- One sub-module: sat_counter (parameter W; ports clk, reset, clr, inc, q). Instantiate it twice.

Test Plan:
- Load-use: lw x5 in E (ResultSrcE=01, RegWriteE=1, RdE=5), Rs1D=5 -> StallF=StallD=FlushE=1, FlushD=0, stall_cnt 0->1.
- Load into x0: RdE=0, Rs1D=0 -> no stall, all controls 0.
- Forward priority: add x3 writes, then add x3 writes again, then Rs1E=3 -> ForwardAE=10. After one more cycle with RegWriteE=0 -> ForwardAE=01. After a further cycle -> 00.
- Taken branch: PCSrcE=1 for one cycle -> FlushD=FlushE=1, StallF=0, flush_cnt=1. Same cycle with a load-use hazard present -> StallD=0, stall_cnt unchanged.
- Saturation and clear: CNT_W=4 with 20 stall cycles -> stall_cnt=15 and holds. cnt_clr=1 concurrent with a stall -> 0 on the next edge.
- Async reset after RdM=7, RegWriteM=1: reset pulse between edges -> shadow cleared immediately; Rs1E=7 gives ForwardAE=00.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_pkg
// Description : Shared encodings and forwarding-select helper for hazard_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] REG_X0 = 5'd0;

    // MEM holds the younger result, so it is checked before WB.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (we_m && (rd_m != REG_X0) && (rs == rd_m))
            fwd_sel = FWD_MEM;
        else if (we_w && (rd_w != REG_X0) && (rs == rd_w))
            fwd_sel = FWD_WB;
        else
            fwd_sel = FWD_RF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear priority.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_cnt_q;
    logic [W-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (clr)
            w_cnt_d = '0;
        else if (inc && (r_cnt_q != {W{1'b1}}))
            w_cnt_d = r_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt_q <= '0;
        else
            r_cnt_q <= w_cnt_d;
    end

    assign q = r_cnt_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Stall/flush/forwarding control with MEM/WB shadow pipeline
//               and saturating hazard-event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             RegWriteE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             cnt_clr,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [4:0] r_rd_m_q, r_rd_w_q;
    logic       r_we_m_q, r_we_w_q;
    logic [4:0] w_rd_m_d, w_rd_w_d;
    logic       w_we_m_d, w_we_w_d;
    logic       w_lw_stall;
    logic       w_stall;

    // Flushed bubbles arrive with RegWriteE=0, so no special shadow handling.
    always_comb begin
        w_rd_m_d = RdE;
        w_we_m_d = RegWriteE;
        w_rd_w_d = r_rd_m_q;
        w_we_w_d = r_we_m_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_m_q <= REG_X0;
            r_we_m_q <= 1'b0;
            r_rd_w_q <= REG_X0;
            r_we_w_q <= 1'b0;
        end else begin
            r_rd_m_q <= w_rd_m_d;
            r_we_m_q <= w_we_m_d;
            r_rd_w_q <= w_rd_w_d;
            r_we_w_q <= w_we_w_d;
        end
    end

    always_comb begin
        w_lw_stall = (ResultSrcE == RESULT_MEM) && RegWriteE && (RdE != REG_X0)
                     && ((Rs1D == RdE) || (Rs2D == RdE));
        // A taken branch makes the Decode instruction wrong-path: flush, don't hold.
        w_stall    = w_lw_stall && !PCSrcE;
    end

    assign StallF    = w_stall;
    assign StallD    = w_stall;
    assign FlushD    = PCSrcE;
    assign FlushE    = w_lw_stall | PCSrcE;
    assign ForwardAE = fwd_sel(Rs1E, r_rd_m_q, r_we_m_q, r_rd_w_q, r_we_w_q);
    assign ForwardBE = fwd_sel(Rs2E, r_rd_m_q, r_we_m_q, r_rd_w_q, r_we_w_q);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (w_stall),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (PCSrcE),
        .q     (flush_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl (CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE;
    logic             RegWriteE;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE;
    logic             cnt_clr;
    logic             StallF, StallD, FlushD, FlushE;
    logic [1:0]       ForwardAE, ForwardBE;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RegWriteE  (RegWriteE),
        .ResultSrcE (ResultSrcE),
        .PCSrcE     (PCSrcE),
        .cnt_clr    (cnt_clr),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0;
        RegWriteE = 1'b0; ResultSrcE = 2'b00; PCSrcE = 1'b0; cnt_clr = 1'b0;
    endtask

    // ctl vector order: {StallF, StallD, FlushD, FlushE}
    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #2;
        checks++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctl got=%b exp=0000", {StallF, StallD, FlushD, FlushE});
        end
        checks++;
        if ({ForwardAE, ForwardBE, stall_cnt, flush_cnt} !== 12'h000) begin
            failures++;
            $display("FAIL reset_fwd_cnt got fa=%b fb=%b sc=%0d fc=%0d exp all 0",
                     ForwardAE, ForwardBE, stall_cnt, flush_cnt);
        end
        #10 reset = 1'b0;
    endtask

    task automatic test_load_use();
        tick();
        idle_inputs();
        ResultSrcE = 2'b01; RegWriteE = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
        #1;
        checks++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b1101) begin
            failures++;
            $display("FAIL load_use_ctl got=%b exp=1101", {StallF, StallD, FlushD, FlushE});
        end
        checks++;
        if (stall_cnt !== 4'd0) begin
            failures++;
            $display("FAIL load_use_cnt_before got=%0d exp=0", stall_cnt);
        end
        tick();
        checks++;
        if (stall_cnt !== 4'd1) begin
            failures++;
            $display("FAIL load_use_cnt_after got=%0d exp=1", stall_cnt);
        end
        // Rs2D path, with Rs1D unrelated
        Rs1D = 5'd9; Rs2D = 5'd5;
        #1;
        checks++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b1101) begin
            failures++;
            $display("FAIL load_use_rs2_ctl got=%b exp=1101", {StallF, StallD, FlushD, FlushE});
        end
        // non-load producer never stalls
        ResultSrcE = 2'b00;
        #1;
        checks++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b0000) begin
            failures++;
            $display("FAIL alu_no_stall_ctl got=%b exp=0000", {StallF, StallD, FlushD, FlushE});
        end
        idle_inputs();
    endtask

    task automatic test_load_x0();
        ResultSrcE = 2'b01; RegWriteE = 1'b1; RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
        #1;
        checks++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b0000) begin
            failures++;
            $display("FAIL load_x0_ctl got=%b exp=0000", {StallF, StallD, FlushD, FlushE});
        end
        tick();
        idle_inputs();
        tick();
        tick();
        checks++;
        if (stall_cnt !== 4'd1) begin
            failures++;
            $display("FAIL load_x0_cnt got=%0d exp=1", stall_cnt);
        end
    endtask

    task automatic test_forward();
        RegWriteE = 1'b1; RdE = 5'd3;
        tick();
        tick();
        RegWriteE = 1'b0; RdE = 5'd0; Rs1E = 5'd3; Rs2E = 5'd3;
        #1;
        checks++;
        if (ForwardAE !== 2'b10) begin
            failures++;
            $display("FAIL fwd_a_mem got=%b exp=10", ForwardAE);
        end
        checks++;
        if (ForwardBE !== 2'b10) begin
            failures++;
            $display("FAIL fwd_b_mem got=%b exp=10", ForwardBE);
        end
        tick();
        checks++;
        if (ForwardAE !== 2'b01) begin
            failures++;
            $display("FAIL fwd_a_wb got=%b exp=01", ForwardAE);
        end
        Rs2E = 5'd4;
        #1;
        checks++;
        if (ForwardBE !== 2'b00) begin
            failures++;
            $display("FAIL fwd_b_nomatch got=%b exp=00", ForwardBE);
        end
        tick();
        checks++;
        if (ForwardAE !== 2'b00) begin
            failures++;
            $display("FAIL fwd_a_none got=%b exp=00", ForwardAE);
        end
        // a write to x0 must never forward
        RegWriteE = 1'b1; RdE = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        tick();
        checks++;
        if ({ForwardAE, ForwardBE} !== 4'b0000) begin
            failures++;
            $display("FAIL fwd_x0 got=%b exp=0000", {ForwardAE, ForwardBE});
        end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_branch();
        PCSrcE = 1'b1;
        #1;
        checks++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) begin
            failures++;
            $display("FAIL branch_ctl got=%b exp=0011", {StallF, StallD, FlushD, FlushE});
        end
        tick();
        checks++;
        if (flush_cnt !== 4'd1) begin
            failures++;
            $display("FAIL branch_flush_cnt got=%0d exp=1", flush_cnt);
        end
        ResultSrcE = 2'b01; RegWriteE = 1'b1; RdE = 5'd5; Rs2D = 5'd5;
        #1;
        checks++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) begin
            failures++;
            $display("FAIL branch_lw_ctl got=%b exp=0011", {StallF, StallD, FlushD, FlushE});
        end
        tick();
        checks++;
        if ({stall_cnt, flush_cnt} !== {4'd1, 4'd2}) begin
            failures++;
            $display("FAIL branch_lw_cnt got sc=%0d fc=%0d exp sc=1 fc=2", stall_cnt, flush_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_saturate_clear();
        ResultSrcE = 2'b01; RegWriteE = 1'b1; RdE = 5'd6; Rs1D = 5'd6;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (stall_cnt !== 4'd15) begin
            failures++;
            $display("FAIL sat_cnt got=%0d exp=15", stall_cnt);
        end
        checks++;
        if (StallD !== 1'b1) begin
            failures++;
            $display("FAIL sat_stall_held got=%b exp=1", StallD);
        end
        cnt_clr = 1'b1;
        tick();
        checks++;
        if ({stall_cnt, flush_cnt} !== 8'h00) begin
            failures++;
            $display("FAIL clr_cnt got sc=%0d fc=%0d exp 0 0", stall_cnt, flush_cnt);
        end
        cnt_clr = 1'b0;
        tick();
        checks++;
        if (stall_cnt !== 4'd1) begin
            failures++;
            $display("FAIL post_clr_cnt got=%0d exp=1", stall_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        RegWriteE = 1'b1; RdE = 5'd7;
        tick();
        RegWriteE = 1'b0; RdE = 5'd0; Rs1E = 5'd7;
        #1;
        checks++;
        if (ForwardAE !== 2'b10) begin
            failures++;
            $display("FAIL pre_reset_fwd got=%b exp=10", ForwardAE);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (ForwardAE !== 2'b00) begin
            failures++;
            $display("FAIL async_reset_fwd got=%b exp=00", ForwardAE);
        end
        checks++;
        if (stall_cnt !== 4'd0) begin
            failures++;
            $display("FAIL async_reset_cnt got=%0d exp=0", stall_cnt);
        end
        #1 reset = 1'b0;
        tick();
        checks++;
        if (ForwardAE !== 2'b00) begin
            failures++;
            $display("FAIL post_reset_fwd got=%b exp=00", ForwardAE);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_load_x0();
        test_forward();
        test_branch();
        test_saturate_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
